// File: rtl/fetch_unpacker.sv
// Fetch stage: reads aligned 64-bit beats, splits them into two instructions and
// queues them for the decoder. Optional counters are enabled by FETCH_STATS_EN.
module fetch_unpacker #(
  parameter int INSTRUCTION_LENGTH = 32,
  parameter int BUS_WIDTH          = 2 * INSTRUCTION_LENGTH,
  parameter int ADDR_WIDTH         = 64,
  parameter int DEPTH              = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         entry_pc,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  input  logic                          mem_resp_valid,
  input  logic [BUS_WIDTH-1:0]          mem_resp_data,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]         instr_pc,
  output logic                          halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                   fetch_count,
  output logic [31:0]                   stall_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t                        state_reg, state_next;
  logic [ADDR_WIDTH-1:0]         fetch_pc_reg, fetch_pc_next;
  logic                          drop_reg, drop_next;
  logic [PTR_W-1:0]              rd_ptr_reg, wr_ptr_reg, wr_ptr_inc;
  logic [CNT_W-1:0]              count_reg, count_after_pop;

  logic [INSTRUCTION_LENGTH-1:0] instr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]         pc_q    [DEPTH];

  logic [ADDR_WIDTH-1:0]         beat_addr;
  logic [INSTRUCTION_LENGTH-1:0] lo_word, hi_word;
  logic                          req_fire, pop, flush;
  logic [1:0]                    enq_n;
  logic [INSTRUCTION_LENGTH-1:0] enq0_instr, enq1_instr;
  logic [ADDR_WIDTH-1:0]         enq0_pc, enq1_pc;

  assign beat_addr  = {fetch_pc_reg[ADDR_WIDTH-1:3], 3'b000};
  assign lo_word    = mem_resp_data[INSTRUCTION_LENGTH-1:0];
  assign hi_word    = mem_resp_data[BUS_WIDTH-1:INSTRUCTION_LENGTH];
  assign wr_ptr_inc = wr_ptr_reg + PTR_W'(1);

  assign instr_valid = (count_reg != '0);
  assign instruction = instr_valid ? instr_q[rd_ptr_reg] : '0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr_reg] : '0;
  assign halted      = (state_reg == S_HALT);

  // Two free slots are required because the single in-flight beat may carry two instructions.
  assign mem_req_addr  = beat_addr;
  assign mem_req_valid = (state_reg == S_REQ) && !drop_reg && (count_reg <= CREDIT_MAX);
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign pop           = instr_valid && instr_ready;
  assign count_after_pop = count_reg - CNT_W'(pop);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    drop_next     = drop_reg && !mem_resp_valid;
    flush         = 1'b0;
    enq_n         = 2'd0;
    enq0_instr    = lo_word;
    enq0_pc       = beat_addr;
    enq1_instr    = hi_word;
    enq1_pc       = beat_addr | ADDR_WIDTH'(4);

    case (state_reg)
      S_IDLE, S_HALT: begin
        if (start) begin
          fetch_pc_next = entry_pc;
          state_next    = S_REQ;
        end
      end
      S_REQ: begin
        if (req_fire) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          fetch_pc_next = beat_addr + ADDR_WIDTH'(8);
          if (fetch_pc_reg[2]) begin
            // Target is the high half: the low half lies before it and is skipped.
            enq0_instr = hi_word;
            enq0_pc    = beat_addr | ADDR_WIDTH'(4);
            if (hi_word == '0) begin
              state_next = S_DRAIN;
            end else begin
              enq_n      = 2'd1;
              state_next = S_REQ;
            end
          end else if (lo_word == '0) begin
            state_next = S_DRAIN;
          end else if (hi_word == '0) begin
            enq_n      = 2'd1;
            state_next = S_DRAIN;
          end else begin
            enq_n      = 2'd2;
            state_next = S_REQ;
          end
        end
      end
      S_DRAIN: begin
        if (count_after_pop == '0) state_next = S_HALT;
      end
      default: state_next = S_IDLE;
    endcase

    // A redirect wins over everything; any response still owed by memory must be swallowed.
    if (redirect_valid) begin
      flush         = 1'b1;
      enq_n         = 2'd0;
      fetch_pc_next = redirect_pc;
      state_next    = S_REQ;
      drop_next     = (((state_reg == S_WAIT) || drop_reg) && !mem_resp_valid) || req_fire;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= '0;
      drop_reg     <= 1'b0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      drop_reg     <= drop_next;
      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(enq_n);
        count_reg  <= count_after_pop + CNT_W'(enq_n);
      end
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (enq_n != 2'd0) begin
      instr_q[wr_ptr_reg] <= enq0_instr;
      pc_q[wr_ptr_reg]    <= enq0_pc;
    end
    if (enq_n == 2'd2) begin
      instr_q[wr_ptr_inc] <= enq1_instr;
      pc_q[wr_ptr_inc]    <= enq1_pc;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_reg, stall_count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_reg <= '0;
      stall_count_reg <= '0;
    end else begin
      if (pop && !redirect_valid) fetch_count_reg <= fetch_count_reg + 32'd1;
      if (instr_ready && !instr_valid && !halted) stall_count_reg <= stall_count_reg + 32'd1;
    end
  end

  assign fetch_count = fetch_count_reg;
  assign stall_count = stall_count_reg;
`endif

endmodule
